// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_fetch_unit_if;
  logic        IMem_req;
  logic [31:0] IMem_addr;
  logic        IMem_gnt;
  logic        IMem_rvalid;
  logic [31:0] IMem_rdata;

  modport master (
    output IMem_req,
    output IMem_addr,
    input  IMem_gnt,
    input  IMem_rvalid,
    input  IMem_rdata
  );

  modport slave (
    input  IMem_req,
    input  IMem_addr,
    output IMem_gnt,
    output IMem_rvalid,
    output IMem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: sequential word fetch with a credit limit,
// an in-order response buffer, a stallable IF->ID output register, and
// redirect handling that flushes the buffer and drops in-flight responses.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_DEPTH = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  if_fetch_unit_if.master        imem,
  input  logic                   Redirect_en,
  input  logic [31:0]            Redirect_PC,
  input  logic                   ID_Stall,
  output logic                   IF_valid,
  output logic [31:0]            IF_PC,
  output logic [31:0]            IF_Instruction,
  output logic                   IF_misaligned
);

  localparam int          AW  = $clog2(FETCH_DEPTH);
  localparam int          CW  = AW + 1;
  localparam int          SW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   buf_pc_q [FETCH_DEPTH];
  logic [31:0]   buf_pc_d [FETCH_DEPTH];
  logic [31:0]   buf_instr_q [FETCH_DEPTH];
  logic [31:0]   buf_instr_d [FETCH_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] buf_count_q, buf_count_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic          misaligned_q, misaligned_d;

  logic          credit_ok;
  logic          req;
  logic          grant;
  logic          rsp_drop;
  logic          rsp_take;
  logic          loadable;
  logic          buf_empty;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [31:0]   redirect_aligned;

  // Handshake decode: credit check, response classification, buffer/bypass routing.
  always_comb begin
    credit_ok        = ({1'b0, outstanding_q} + {1'b0, buf_count_q}) < SW'(FETCH_DEPTH);
    req              = Reset_n & ~Redirect_en & credit_ok;
    grant            = req & imem.IMem_gnt;
    rsp_drop         = imem.IMem_rvalid & (discard_q != '0);
    rsp_take         = imem.IMem_rvalid & (discard_q == '0) & ~Redirect_en;
    loadable         = ~if_valid_q | ~ID_Stall;
    buf_empty        = (buf_count_q == '0);
    pop              = loadable & ~buf_empty;
    bypass           = loadable & buf_empty & rsp_take;
    push             = rsp_take & ~bypass;
    redirect_aligned = {Redirect_PC[31:2], 2'b00};
  end

  assign imem.IMem_req  = req;
  assign imem.IMem_addr = fetch_pc_q;

  // Next-state for PCs, counters, buffer and output register; redirect wins last.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem.IMem_rvalid);
    discard_d     = discard_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    buf_count_d   = buf_count_q + CW'(push) - CW'(pop);
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    misaligned_d  = Redirect_en & (Redirect_PC[1:0] != 2'b00);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp_drop) begin
      discard_d = discard_q - CW'(1);
    end
    if (rsp_take) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (push) begin
      buf_pc_d[wr_ptr_q]    = rsp_pc_q;
      buf_instr_d[wr_ptr_q] = imem.IMem_rdata;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (loadable) begin
      if (pop) begin
        if_valid_d = 1'b1;
        if_pc_d    = buf_pc_q[rd_ptr_q];
        if_instr_d = buf_instr_q[rd_ptr_q];
      end else if (bypass) begin
        if_valid_d = 1'b1;
        if_pc_d    = rsp_pc_q;
        if_instr_d = imem.IMem_rdata;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = NOP;
      end
    end

    if (Redirect_en) begin
      fetch_pc_d    = redirect_aligned;
      rsp_pc_d      = redirect_aligned;
      outstanding_d = outstanding_q - CW'(imem.IMem_rvalid);
      discard_d     = outstanding_q - CW'(imem.IMem_rvalid);
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      buf_count_d   = '0;
      if_valid_d    = 1'b0;
      if_instr_d    = NOP;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      buf_count_q   <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= NOP;
      misaligned_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      buf_count_q   <= buf_count_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign IF_valid       = if_valid_q;
  assign IF_PC          = if_pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_misaligned  = misaligned_q;

  a_no_overflow : assert property (@(posedge Clk) disable iff (!Reset_n)
    !(push && !pop && (buf_count_q == CW'(FETCH_DEPTH))));
  a_no_outstanding_underflow : assert property (@(posedge Clk) disable iff (!Reset_n)
    !(imem.IMem_rvalid && (outstanding_q == '0)));
  a_discard_bounded : assert property (@(posedge Clk) disable iff (!Reset_n)
    discard_q <= outstanding_q);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: a responsive memory model,
// a sequential-PC reference model feeding an expectation queue, and a
// negedge monitor that checks every consumed instruction and bus rule.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Redirect_en;
  logic [31:0] Redirect_PC;
  logic        ID_Stall;
  logic        IF_valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_misaligned;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(
    .RESET_PC    (RESET_PC),
    .FETCH_DEPTH (2)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .imem           (imem_bus),
    .Redirect_en    (Redirect_en),
    .Redirect_PC    (Redirect_PC),
    .ID_Stall       (ID_Stall),
    .IF_valid       (IF_valid),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .IF_misaligned  (IF_misaligned)
  );

  always #5 Clk = ~Clk;

  int          num_compared   = 0;
  int          num_mismatched = 0;
  exp_t        exp_q[$];
  logic [31:0] pending[$];
  logic [31:0] exp_pc;

  logic [31:0] model_fetch;
  bit          prev_mis;
  bit          after_redirect;
  bit          hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  bit          prev_wait;
  logic [31:0] wait_addr;
  bit          rst_edge;
  int          since_rst;
  int          first_valid_idx;
  int          n_consumed;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; the memory answers the oldest granted request.
  task automatic applyStimulus(input bit gnt, input int rv_pct, input bit stall,
                               input bit redir, input logic [31:0] target);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    imem_bus.IMem_gnt = gnt;
    if (pending.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      imem_bus.IMem_rvalid = 1'b1;
      imem_bus.IMem_rdata  = memWord(pending.pop_front());
    end else begin
      imem_bus.IMem_rvalid = 1'b0;
      imem_bus.IMem_rdata  = $urandom;
    end
    ID_Stall    = stall;
    Redirect_en = redir;
    Redirect_PC = target;
    if (redir) begin
      exp_q.delete();
      exp_pc = target & ~32'h3;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: exp_pc, instr: memWord(exp_pc)});
      exp_pc += 32'd4;
    end
  endtask

  task automatic randomCycles(input int n, input int gnt_pct, input int rv_pct,
                              input int stall_pct, input int redir_pct);
    logic [31:0] tgt;
    bit          r;
    for (int i = 0; i < n; i++) begin
      r   = ($urandom_range(0, 99) < redir_pct);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 + ($urandom & 32'h7) : ($urandom & 32'h0000_0FFF);
      applyStimulus($urandom_range(0, 99) < gnt_pct, rv_pct,
                    $urandom_range(0, 99) < stall_pct, r, tgt);
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      Reset_n              = 1'b0;
      imem_bus.IMem_gnt    = 1'b0;
      imem_bus.IMem_rvalid = 1'b0;
      Redirect_en          = 1'b0;
      ID_Stall             = 1'b0;
      pending.delete();
      exp_q.delete();
      exp_pc = RESET_PC;
    end
  endtask

  // Monitor: inspects settled outputs each negedge and scores events of the coming edge.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      checkOutput("req_in_reset", {31'b0, imem_bus.IMem_req}, 32'd0);
      model_fetch     = RESET_PC;
      prev_mis        = 1'b0;
      after_redirect  = 1'b0;
      hold_valid      = 1'b0;
      prev_wait       = 1'b0;
      rst_edge        = 1'b1;
      since_rst       = 0;
      first_valid_idx = -1;
      n_consumed      = 0;
    end else begin
      if (rst_edge) begin
        checkOutput("reset_IF_valid", {31'b0, IF_valid}, 32'd0);
        checkOutput("reset_IF_PC", IF_PC, 32'd0);
        checkOutput("reset_IF_Instruction", IF_Instruction, NOP);
        rst_edge = 1'b0;
      end
      checkOutput("IF_misaligned", {31'b0, IF_misaligned}, {31'b0, prev_mis});
      if (after_redirect)
        checkOutput("valid_after_redirect", {31'b0, IF_valid}, 32'd0);
      if (hold_valid) begin
        checkOutput("stall_hold_valid", {31'b0, IF_valid}, 32'd1);
        checkOutput("stall_hold_pc", IF_PC, hold_pc);
        checkOutput("stall_hold_instr", IF_Instruction, hold_instr);
      end
      if (!IF_valid)
        checkOutput("nop_when_invalid", IF_Instruction, NOP);
      if (prev_wait && imem_bus.IMem_req)
        checkOutput("addr_stable_wait", imem_bus.IMem_addr, wait_addr);
      if (imem_bus.IMem_req && imem_bus.IMem_gnt) begin
        checkOutput("fetch_addr", imem_bus.IMem_addr, model_fetch);
        model_fetch += 32'd4;
        pending.push_back(imem_bus.IMem_addr);
      end
      if (Redirect_en) begin
        checkOutput("req_during_redirect", {31'b0, imem_bus.IMem_req}, 32'd0);
        model_fetch = Redirect_PC & ~32'h3;
      end
      if (IF_valid && first_valid_idx < 0)
        first_valid_idx = since_rst;
      if (IF_valid && !ID_Stall && !Redirect_en) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_underrun", IF_PC, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("IF_PC", IF_PC, e.pc);
          checkOutput("IF_Instruction", IF_Instruction, e.instr);
        end
      end
      prev_mis       = Redirect_en && (Redirect_PC[1:0] != 2'b00);
      after_redirect = Redirect_en;
      hold_valid     = IF_valid && ID_Stall && !Redirect_en;
      hold_pc        = IF_PC;
      hold_instr     = IF_Instruction;
      prev_wait      = imem_bus.IMem_req && !imem_bus.IMem_gnt;
      wait_addr      = imem_bus.IMem_addr;
      since_rst++;
    end
  end

  // Stimulus sequence: directed scenarios followed by randomized traffic.
  initial begin
    Reset_n              = 1'b0;
    Redirect_en          = 1'b0;
    Redirect_PC          = '0;
    ID_Stall             = 1'b0;
    imem_bus.IMem_gnt    = 1'b0;
    imem_bus.IMem_rvalid = 1'b0;
    imem_bus.IMem_rdata  = '0;
    exp_pc               = RESET_PC;

    $display("[TB] reset and streaming");
    doReset(3);
    repeat (10) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);
    @(negedge Clk);
    #1;
    checkOutput("first_valid_cycle", first_valid_idx, 32'd2);
    checkOutput("one_per_cycle", n_consumed, 32'd8);

    $display("[TB] decode stall");
    repeat (8) applyStimulus(1'b1, 100, 1'b1, 1'b0, '0);
    @(negedge Clk);
    #1;
    checkOutput("credit_full_req", {31'b0, imem_bus.IMem_req}, 32'd0);
    checkOutput("credit_full_valid", {31'b0, IF_valid}, 32'd1);
    repeat (6) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);

    $display("[TB] grant withheld");
    repeat (4) applyStimulus(1'b0, 100, 1'b0, 1'b0, '0);
    @(negedge Clk);
    #1;
    checkOutput("req_while_no_gnt", {31'b0, imem_bus.IMem_req}, 32'd1);
    repeat (6) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);

    $display("[TB] redirect with requests in flight");
    repeat (3) applyStimulus(1'b1, 0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 32'h0000_0200);
    repeat (10) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);

    $display("[TB] redirect under stall");
    repeat (4) applyStimulus(1'b1, 100, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 100, 1'b1, 1'b1, 32'h0000_0400);
    repeat (8) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);

    $display("[TB] misaligned redirect and wraparound");
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 32'h0000_0103);
    repeat (8) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (8) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 32'h0000_0040);
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 32'h0000_0081);
    repeat (8) applyStimulus(1'b1, 60, 1'b0, 1'b0, '0);

    $display("[TB] random traffic");
    randomCycles(1500, 70, 60, 30, 4);
    doReset(2);
    randomCycles(1500, 50, 40, 50, 8);
    repeat (10) applyStimulus(1'b1, 100, 1'b0, 1'b0, '0);
    @(negedge Clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
